// File: rtl/data_memory_lsu_if.sv
// Load/store request and response bus between the MEM stage and the data memory.
interface data_memory_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [2:0]            reqFunc3;
  logic [ADDR_WIDTH-1:0] reqAddress;
  logic [31:0]           reqWriteData;
  logic                  respValid;
  logic [31:0]           respReadData;
  logic                  respError;
  logic [1:0]            respErrorCode;

  modport master (
    output reqValid, reqWrite, reqFunc3, reqAddress, reqWriteData,
    input  reqReady, respValid, respReadData, respError, respErrorCode
  );

  modport slave (
    input  reqValid, reqWrite, reqFunc3, reqAddress, reqWriteData,
    output reqReady, respValid, respReadData, respError, respErrorCode
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-lane-aware data memory for the MEM stage: SB/SH/SW merge, LB/LH/LW/LBU/LHU extract,
// in-order responses after a fixed latency with func3/alignment/range error reporting.
module data_memory_lsu #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic              clock,
  input logic              resetN,
  data_memory_lsu_if.slave bus
);
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  // Address bits at or below the word-index field; anything set above it is out of range.
  localparam logic [ADDR_WIDTH-1:0] InRangeMask = ADDR_WIDTH'((64'd1 << (IdxW + 2)) - 64'd1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] clr_cnt_q, clr_cnt_d;
  logic            clr_we;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic [1:0]      off;
  logic [IdxW-1:0] widx;
  logic            is_half, is_word;
  logic            err_func3, err_align, err_range, req_err;
  logic [1:0]      err_code;
  logic [3:0]      byte_en;
  logic [31:0]     wr_lanes, rd_word, ld_data;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  logic            pv_q [READ_LATENCY];
  logic            pe_q [READ_LATENCY];
  logic [1:0]      pc_q [READ_LATENCY];
  logic [31:0]     pd_q [READ_LATENCY];

  assign bus.reqReady = (state_q == StReady);
  assign accept       = bus.reqValid & bus.reqReady & resetN;
  assign off          = bus.reqAddress[1:0];
  assign widx         = bus.reqAddress[IdxW+1:2];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      StClear: begin
        if (CLEAR_ON_RESET) begin
          clr_we    = resetN;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == IdxW'(DEPTH_WORDS - 1)) state_d = StReady;
        end else begin
          state_d = StReady;
        end
      end
      StReady: state_d = StReady;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    is_half = (bus.reqFunc3[1:0] == 2'b01);
    is_word = (bus.reqFunc3[1:0] == 2'b10);
    if (bus.reqWrite) begin
      err_func3 = bus.reqFunc3[2] | (bus.reqFunc3[1:0] == 2'b11);
    end else begin
      err_func3 = (bus.reqFunc3[1:0] == 2'b11) | (bus.reqFunc3[2] & bus.reqFunc3[1]);
    end
    err_align = (is_half & off[0]) | (is_word & (off != 2'b00));
    err_range = |(bus.reqAddress & ~InRangeMask);
    req_err   = err_func3 | err_align | err_range;
    if (err_func3)      err_code = 2'b11;
    else if (err_align) err_code = 2'b01;
    else if (err_range) err_code = 2'b10;
    else                err_code = 2'b00;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = bus.reqWriteData;
    case (bus.reqFunc3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << off;
        wr_lanes = {4{bus.reqWriteData[7:0]}};
      end
      2'b01: begin
        byte_en  = off[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{bus.reqWriteData[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (accept && bus.reqWrite && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[widx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[widx];
    rd_byte = rd_word[{off, 3'b000} +: 8];
    rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.reqFunc3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = '0;
    endcase
    if (bus.reqWrite || req_err) ld_data = '0;
  end

  // Response delay line; stage 0 captures on the accepting edge, last stage drives the bus.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= 1'b0;
        pc_q[i] <= 2'b00;
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= accept;
      pe_q[0] <= accept & req_err;
      pc_q[0] <= accept ? err_code : 2'b00;
      pd_q[0] <= accept ? ld_data : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pc_q[i] <= pc_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign bus.respValid     = pv_q[READ_LATENCY-1];
  assign bus.respError     = pe_q[READ_LATENCY-1];
  assign bus.respErrorCode = pc_q[READ_LATENCY-1];
  assign bus.respReadData  = pd_q[READ_LATENCY-1];
endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: directed and random load/store traffic against a word-array model.
module tb_data_memory_lsu;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 1024;
  localparam int unsigned LAT = 3;

  typedef struct {int cyc; logic err; logic [1:0] code; logic [31:0] data;} resp_t;
  typedef struct {logic err; logic [1:0] code; logic [31:0] data;} exp_t;
  typedef struct {
    logic w; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
    logic err; logic [1:0] code; logic [31:0] data;
  } vec_t;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   idle_bad = 0;
  bit   mon_en = 1'b0;
  resp_t got_q[$];
  int    acc_q[$];
  exp_t  exp_q[$];
  logic [31:0] model_mem [DW];

  data_memory_lsu_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_lsu #(
    .ADDR_WIDTH(AW), .DEPTH_WORDS(DW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin : monitor
    resp_t r;
    cyc++;
    if (resetN && bus.reqValid === 1'b1 && bus.reqReady === 1'b1) acc_q.push_back(cyc);
    if (bus.respValid === 1'b1) begin
      r.cyc = cyc; r.err = bus.respError; r.code = bus.respErrorCode; r.data = bus.respReadData;
      got_q.push_back(r);
    end else if (mon_en && bus.respReadData !== 32'h0) begin
      idle_bad++;
    end
  end

  // Reference: word array indexed by byte address / 4, lanes handled with plain arithmetic.
  function automatic exp_t model_req(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int unsigned lane, idx, size;
    logic [31:0] v;
    e.err = 1'b0; e.code = 2'b00; e.data = 32'h0;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lane = a % 4;
    idx  = (a / 4) % DW;
    if (w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) begin
      e.err = 1'b1; e.code = 2'b11;
    end else if (a % size != 0) begin
      e.err = 1'b1; e.code = 2'b01;
    end else if (a >= 32'(DW * 4)) begin
      e.err = 1'b1; e.code = 2'b10;
    end else if (w) begin
      for (int i = 0; i < int'(size); i++) model_mem[idx][8*(int'(lane)+i) +: 8] = wd[8*i +: 8];
    end else begin
      v = model_mem[idx] >> (8 * lane);
      if (size == 1)      e.data = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      else if (size == 2) e.data = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                e.data = v;
    end
    return e;
  endfunction

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(posedge clock); #1;
    bus.reqValid = 1'b1; bus.reqWrite = w; bus.reqFunc3 = f3;
    bus.reqAddress = a; bus.reqWriteData = wd;
  endtask

  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    drive(w, f3, a, wd);
    exp_q.push_back(model_req(w, f3, a, wd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      bus.reqValid = 1'b0;
    end
  endtask

  task automatic wait_resp(input int n);
    for (int t = 0; t < 200 && got_q.size() < n; t++) @(negedge clock);
  endtask

  task automatic flush_queues();
    got_q.delete(); acc_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqFunc3 = 3'b000;
    bus.reqAddress = '0; bus.reqWriteData = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({bus.reqReady, bus.respValid, bus.respError, bus.respErrorCode, bus.respReadData}
        !== 37'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b code=%b data=%h, required all 0",
               bus.reqReady, bus.respValid, bus.respError, bus.respErrorCode, bus.respReadData);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_clear(input string name);
    int n = 0;
    @(posedge clock); #1;
    resetN = 1'b1;
    @(negedge clock);
    while (bus.reqReady !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clock);
    end
    checks++;
    if (n != int'(DW)) begin
      errors++;
      $display("FAIL %s: reqReady low for %0d cycles, required %0d", name, n, DW);
    end
    for (int i = 0; i < int'(DW); i++) model_mem[i] = 32'h0;
    flush_queues();
  endtask

  task automatic test_directed();
    vec_t tbl [24];
    exp_t e;
    resp_t g;
    int c;
    tbl = '{
      '{1'b0, 3'd2, 32'h0000, 32'h0, 1'b0, 2'd0, 32'h0},
      '{1'b0, 3'd2, 32'h0FFC, 32'h0, 1'b0, 2'd0, 32'h0},
      '{1'b1, 3'd2, 32'h0010, 32'h11223344, 1'b0, 2'd0, 32'h0},
      '{1'b1, 3'd0, 32'h0012, 32'h000000AA, 1'b0, 2'd0, 32'h0},
      '{1'b0, 3'd2, 32'h0010, 32'h0, 1'b0, 2'd0, 32'h11AA3344},
      '{1'b0, 3'd0, 32'h0012, 32'h0, 1'b0, 2'd0, 32'hFFFFFFAA},
      '{1'b0, 3'd4, 32'h0012, 32'h0, 1'b0, 2'd0, 32'h000000AA},
      '{1'b1, 3'd1, 32'h0022, 32'h00008001, 1'b0, 2'd0, 32'h0},
      '{1'b0, 3'd1, 32'h0022, 32'h0, 1'b0, 2'd0, 32'hFFFF8001},
      '{1'b0, 3'd5, 32'h0022, 32'h0, 1'b0, 2'd0, 32'h00008001},
      '{1'b0, 3'd2, 32'h0020, 32'h0, 1'b0, 2'd0, 32'h80010000},
      '{1'b0, 3'd2, 32'h0013, 32'h0, 1'b1, 2'd1, 32'h0},
      '{1'b1, 3'd2, 32'h0013, 32'hDEADBEEF, 1'b1, 2'd1, 32'h0},
      '{1'b1, 3'd2, 32'h1000, 32'hDEADBEEF, 1'b1, 2'd2, 32'h0},
      '{1'b0, 3'd2, 32'h0010, 32'h0, 1'b0, 2'd0, 32'h11AA3344},
      '{1'b0, 3'd2, 32'h0000, 32'h0, 1'b0, 2'd0, 32'h0},
      '{1'b0, 3'd3, 32'h0010, 32'h0, 1'b1, 2'd3, 32'h0},
      '{1'b1, 3'd4, 32'h0010, 32'h12345678, 1'b1, 2'd3, 32'h0},
      '{1'b0, 3'd3, 32'h1001, 32'h0, 1'b1, 2'd3, 32'h0},
      '{1'b0, 3'd1, 32'h1001, 32'h0, 1'b1, 2'd1, 32'h0},
      '{1'b0, 3'd0, 32'h1003, 32'h0, 1'b1, 2'd2, 32'h0},
      '{1'b1, 3'd0, 32'h0013, 32'h5A5A5A5A, 1'b0, 2'd0, 32'h0},
      '{1'b0, 3'd2, 32'h0010, 32'h0, 1'b0, 2'd0, 32'h5AAA3344},
      '{1'b0, 3'd1, 32'h0012, 32'h0, 1'b0, 2'd0, 32'h00005AAA}
    };
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd);
      void'(model_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd));
      e.err = tbl[i].err; e.code = tbl[i].code; e.data = tbl[i].data;
      exp_q.push_back(e);
    end
    idle(1);
    wait_resp(24);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0 || acc_q.size() == 0) begin
        errors++;
        $display("FAIL directed[%0d]: no response, required err=%b code=%0d data=%h",
                 i, e.err, e.code, e.data);
      end else begin
        g = got_q.pop_front();
        c = acc_q.pop_front();
        if (g.cyc - c != int'(LAT) || g.err !== e.err || g.code !== e.code || g.data !== e.data)
        begin
          errors++;
          $display("FAIL directed[%0d]: got lat=%0d err=%b code=%0d data=%h, required lat=%0d err=%b code=%0d data=%h",
                   i, g.cyc - c, g.err, g.code, g.data, LAT, e.err, e.code, e.data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    exp_t e;
    resp_t g;
    int c;
    for (int i = 0; i < 4; i++) a[i] = 32'($urandom_range(0, DW - 1)) * 4;
    for (int i = 0; i < 4; i++) send(1'b1, 3'd2, a[i], $urandom);
    for (int i = 0; i < 4; i++) send(1'b0, 3'd2, a[i], 32'h0);
    send(1'b1, 3'd1, 32'h0302, $urandom);
    send(1'b0, 3'd5, 32'h0302, 32'h0);
    idle(1);
    wait_resp(10);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0 || acc_q.size() == 0) begin
        errors++;
        $display("FAIL back_to_back[%0d]: no response, required data=%h", i, e.data);
      end else begin
        g = got_q.pop_front();
        c = acc_q.pop_front();
        if (g.cyc - c != int'(LAT) || g.err !== e.err || g.code !== e.code || g.data !== e.data)
        begin
          errors++;
          $display("FAIL back_to_back[%0d]: got lat=%0d err=%b code=%0d data=%h, required lat=%0d err=%b code=%0d data=%h",
                   i, g.cyc - c, g.err, g.code, g.data, LAT, e.err, e.code, e.data);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    exp_t e;
    resp_t g;
    int c;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    wait_resp(n);
    repeat (LAT + 2) @(negedge clock);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0 || acc_q.size() == 0) begin
        errors++;
        $display("FAIL random[%0d]: no response, required err=%b code=%0d data=%h",
                 i, e.err, e.code, e.data);
      end else begin
        g = got_q.pop_front();
        c = acc_q.pop_front();
        if (g.cyc - c != int'(LAT) || g.err !== e.err || g.code !== e.code || g.data !== e.data)
        begin
          errors++;
          $display("FAIL random[%0d]: got lat=%0d err=%b code=%0d data=%h, required lat=%0d err=%b code=%0d data=%h",
                   i, g.cyc - c, g.err, g.code, g.data, LAT, e.err, e.code, e.data);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL random_extra: got %0d unexpected responses, required 0", got_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 3'd2, 32'h0040, 32'hCAFEF00D);
    idle(1);
    repeat (LAT + 2) @(negedge clock);
    flush_queues();
    drive(1'b0, 3'd2, 32'h0040, 32'h0);
    drive(1'b0, 3'd2, 32'h0040, 32'h0);
    @(posedge clock); #1;
    resetN = 1'b0;
    bus.reqValid = 1'b0;
    repeat (LAT + 3) @(negedge clock);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL stale_after_reset: got %0d responses, required 0", got_q.size());
    end
    test_clear("clear_after_stream_reset");
    send(1'b0, 3'd2, 32'h0040, 32'h0);
    idle(1);
    wait_resp(1);
    checks++;
    if (got_q.size() != 1 || got_q[0].data !== 32'h0 || got_q[0].err !== 1'b0) begin
      errors++;
      $display("FAIL reload_after_clear: got %0d responses data=%h, required 1 response data=00000000",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'hX);
    end
    flush_queues();
  endtask

  task automatic test_midclear_reset();
    @(posedge clock); #1;
    resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    repeat (300) @(posedge clock);
    #1 resetN = 1'b0;
    repeat (2) @(negedge clock);
    test_clear("clear_restart_midclear");
  endtask

  task automatic test_idle_zero();
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL idle_data_zero: got %0d idle cycles with nonzero data, required 0", idle_bad);
    end
  endtask

  initial begin
    test_reset();
    test_clear("clear_initial");
    test_directed();
    test_back_to_back();
    test_random(400);
    test_reset_midstream();
    test_midclear_reset();
    test_back_to_back();
    test_idle_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
